// File: rtl/nascom_vid_pkg.sv
// nascom_vid_pkg
//   Shared constants for the Nascom 2 video timing path: default raster
//   geometry, counter widths, VRAM address width and the bit positions of
//   the row flags returned by the 32x2 video decode PROM.
//   Optional feature macro used by the top: NASCOM_VID_FRAME_COUNT_EN.
package nascom_vid_pkg;

  // Default raster geometry (character periods / scanlines / rows).
  localparam int DEF_H_TOTAL      = 64;
  localparam int DEF_H_ACTIVE     = 48;
  localparam int DEF_H_SYNC_START = 52;
  localparam int DEF_H_SYNC_LEN   = 4;
  localparam int DEF_SCAN_PER_ROW = 14;
  localparam int DEF_SCAN_LAST    = 18;
  localparam int DEF_ROWS_TOTAL   = 22;

  // Counter and address widths.
  localparam int COL_W   = 6;
  localparam int SCAN_W  = 5;
  localparam int ROW_W   = 5;
  localparam int VRAM_AW = 10;

  // Bit positions inside vid_flags (raw PROM d1/d0).
  localparam int FLAG_D0 = 0;
  localparam int FLAG_D1 = 1;

endpackage

// File: rtl/nascom_vid_hcount.sv
// nascom_vid_hcount
//   Character column counter plus horizontal sync/blank decode.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     adv         - character-period advance (already qualified by the top)
//     col         - current column (registered)
//     line_end    - high in the clk where the column wraps to 0
//     hsync       - active-high horizontal sync, decoded from col
//     hblank      - active-high horizontal blank, decoded from col
module nascom_vid_hcount
  import nascom_vid_pkg::*;
#(
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [COL_W-1:0] col,
  output logic             line_end,
  output logic             hsync,
  output logic             hblank
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_TOTAL - 1);

  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] col_d;

  always_comb begin
    col_d    = col_q;
    line_end = 1'b0;
    if (adv) begin
      if (col_q == COL_LAST) begin
        col_d    = '0;
        line_end = 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

  // Decodes are taken straight from the registered column so they line up
  // with col and char_addr without an extra pipeline stage.
  assign col    = col_q;
  assign hblank = (int'(col_q) >= H_ACTIVE);
  assign hsync  = (int'(col_q) >= H_SYNC_START) &&
                  (int'(col_q) <  H_SYNC_START + H_SYNC_LEN);

endmodule

// File: rtl/nascom_vid_timing.sv
// nascom_vid_timing
//   Nascom 2 video timing generator. Counts columns, scanlines and text
//   rows, presents the row number to the video decode PROM and registers
//   the PROM result as per-row flags.
//   Ports:
//     clk, rst_n   - 16 MHz clock, asynchronous active-low reset
//     ch_en        - 1 MHz character-clock enable (one clk wide)
//     prom_a       - row number to PROM a4..a0
//     prom_ce_n    - PROM chip enable, active low
//     prom_d       - PROM data d1,d0
//     vid_flags    - registered PROM data for the current row
//     char_addr    - VRAM address {row[3:0], col[5:0]}
//     scan         - scanline within the current row
//     hsync/hblank - horizontal sync and blank
//     frame_start  - one-clk pulse at the frame wrap
//     frame_cnt    - frame counter, only with NASCOM_VID_FRAME_COUNT_EN
module nascom_vid_timing
  import nascom_vid_pkg::*;
#(
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int SCAN_PER_ROW = DEF_SCAN_PER_ROW,
  parameter int SCAN_LAST    = DEF_SCAN_LAST,
  parameter int ROWS_TOTAL   = DEF_ROWS_TOTAL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ch_en,
  output logic [ROW_W-1:0]   prom_a,
  output logic               prom_ce_n,
  input  logic [1:0]         prom_d,
  output logic [1:0]         vid_flags,
  output logic [VRAM_AW-1:0] char_addr,
  output logic [SCAN_W-1:0]  scan,
  output logic               hsync,
  output logic               hblank,
  output logic               frame_start
`ifdef NASCOM_VID_FRAME_COUNT_EN
  ,
  output logic [7:0]         frame_cnt
`endif
);

  if (H_TOTAL > 64 || H_TOTAL < 2) begin : g_bad_h_total
    $error("nascom_vid_timing: H_TOTAL must be in 2..64");
  end
  if (SCAN_LAST > 32 || SCAN_LAST < 1 || SCAN_PER_ROW > 32 || SCAN_PER_ROW < 1) begin : g_bad_scan
    $error("nascom_vid_timing: scanline counts must be in 1..32");
  end
  if (ROWS_TOTAL > 32 || ROWS_TOTAL < 1) begin : g_bad_rows
    $error("nascom_vid_timing: ROWS_TOTAL must be in 1..32");
  end

  localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(ROWS_TOTAL - 1);
  localparam logic [SCAN_W-1:0] SCAN_NORM_IDX = SCAN_W'(SCAN_PER_ROW - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST_IDX = SCAN_W'(SCAN_LAST - 1);

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        flags_q, flags_d;
  logic              ce_n_q, ce_n_d;
  logic              fs_q, fs_d;
  logic [SCAN_W-1:0] scan_end_idx;

  logic              adv;
  logic [COL_W-1:0]  col;
  logic              line_end;

  // prom_ce_n stays high for the first edge after reset release, so gating
  // on it keeps a ch_en that lands on that edge from advancing the raster.
  assign adv = ch_en & ~ce_n_q;

  nascom_vid_hcount #(
    .H_TOTAL      (H_TOTAL),
    .H_ACTIVE     (H_ACTIVE),
    .H_SYNC_START (H_SYNC_START),
    .H_SYNC_LEN   (H_SYNC_LEN)
  ) u_hcount (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (adv),
    .col      (col),
    .line_end (line_end),
    .hsync    (hsync),
    .hblank   (hblank)
  );

  always_comb begin
    scan_d       = scan_q;
    row_d        = row_q;
    flags_d      = flags_q;
    ce_n_d       = 1'b0;
    fs_d         = 1'b0;
    scan_end_idx = (row_q == ROW_LAST) ? SCAN_LAST_IDX : SCAN_NORM_IDX;

    if (line_end) begin
      if (scan_q == scan_end_idx) begin
        scan_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          fs_d  = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        scan_d = scan_q + 1'b1;
      end
    end

    // The row address has been on the PROM since col 0, so sampling at
    // col 1 gives it a full character period to settle.
    if (adv && (col == COL_W'(1)) && (scan_q == '0)) begin
      flags_d[FLAG_D0] = prom_d[FLAG_D0];
      flags_d[FLAG_D1] = prom_d[FLAG_D1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q  <= '0;
      row_q   <= '0;
      flags_q <= 2'b11;
      ce_n_q  <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      scan_q  <= scan_d;
      row_q   <= row_d;
      flags_q <= flags_d;
      ce_n_q  <= ce_n_d;
      fs_q    <= fs_d;
    end
  end

`ifdef NASCOM_VID_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (fs_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  // Rows 16 and up alias VRAM through row[3:0]; the PROM flags blank them.
  assign char_addr   = {row_q[3:0], col};
  assign prom_a      = row_q;
  assign prom_ce_n   = ce_n_q;
  assign vid_flags   = flags_q;
  assign scan        = scan_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_nascom_vid_timing.sv
// tb_nascom_vid_timing
//   Directed bench for nascom_vid_timing with a reference raster model and
//   an expected-value queue.
module tb_nascom_vid_timing;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ch_en = 1'b0;
  logic [4:0] prom_a;
  logic       prom_ce_n;
  logic [1:0] prom_d;
  logic [1:0] vid_flags;
  logic [9:0] char_addr;
  logic [4:0] scan;
  logic       hsync;
  logic       hblank;
  logic       frame_start;
`ifdef NASCOM_VID_FRAME_COUNT_EN
  logic [7:0] frame_cnt;
`endif

  nascom_vid_timing dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_en       (ch_en),
    .prom_a      (prom_a),
    .prom_ce_n   (prom_ce_n),
    .prom_d      (prom_d),
    .vid_flags   (vid_flags),
    .char_addr   (char_addr),
    .scan        (scan),
    .hsync       (hsync),
    .hblank      (hblank),
    .frame_start (frame_start)
`ifdef NASCOM_VID_FRAME_COUNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] prom_model(input int r);
    if (r == 0)      return 2'b01;
    else if (r == 1) return 2'b00;
    else             return 2'b11;
  endfunction

  always_comb prom_d = prom_model(int'(prom_a));

  typedef struct {
    logic [9:0] addr;
    logic [4:0] scan;
    logic [4:0] row;
    logic [1:0] flags;
    logic       hs;
    logic       hb;
    logic       fs;
    logic       ce_n;
    logic [7:0] fcnt;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  int         m_col, m_scan, m_row, m_fcnt;
  logic [1:0] m_flags;
  logic       m_ce_n, m_fs;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    m_col = 0; m_scan = 0; m_row = 0; m_fcnt = 0;
    m_flags = 2'b11; m_ce_n = 1'b1; m_fs = 1'b0;
  endtask

  task automatic pushExpected();
    exp_t e;
    logic [31:0] r, c;
    r = m_row;
    c = m_col;
    e.addr  = {r[3:0], c[5:0]};
    e.scan  = 5'(m_scan);
    e.row   = 5'(m_row);
    e.flags = m_flags;
    e.hs    = (m_col >= 52) && (m_col < 56);
    e.hb    = (m_col >= 48);
    e.fs    = m_fs;
    e.ce_n  = m_ce_n;
    e.fcnt  = 8'(m_fcnt);
    sb.push_back(e);
  endtask

  task automatic compareAll();
    exp_t e;
    e = sb.pop_front();
    checkOutput("char_addr", 16'(char_addr), 16'(e.addr));
    checkOutput("scan", 16'(scan), 16'(e.scan));
    checkOutput("prom_a", 16'(prom_a), 16'(e.row));
    checkOutput("vid_flags", 16'(vid_flags), 16'(e.flags));
    checkOutput("hsync", 16'(hsync), 16'(e.hs));
    checkOutput("hblank", 16'(hblank), 16'(e.hb));
    checkOutput("frame_start", 16'(frame_start), 16'(e.fs));
    checkOutput("prom_ce_n", 16'(prom_ce_n), 16'(e.ce_n));
`ifdef NASCOM_VID_FRAME_COUNT_EN
    checkOutput("frame_cnt", 16'(frame_cnt), 16'(e.fcnt));
`endif
  endtask

  // One clk of stimulus: update the model, queue the expectation, clock the
  // DUT and compare just after the edge.
  task automatic applyStimulus(input logic en);
    ch_en = en;
    m_fs  = 1'b0;
    if (en) begin
      if (m_col == 1 && m_scan == 0) m_flags = prom_model(m_row);
      if (m_col == 63) begin
        m_col = 0;
        if (m_scan == ((m_row == 21) ? 17 : 13)) begin
          m_scan = 0;
          if (m_row == 21) begin
            m_row  = 0;
            m_fs   = 1'b1;
            m_fcnt = (m_fcnt + 1) % 256;
          end else begin
            m_row++;
          end
        end else begin
          m_scan++;
        end
      end else begin
        m_col++;
      end
    end
    pushExpected();
    @(posedge clk);
    #1;
    ch_en = 1'b0;
    compareAll();
  endtask

  initial begin
    int fs_count, l20, l21, prev_a;
    int seq[$];

    // Reset state, held across two edges with ch_en active.
    modelReset();
    ch_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pushExpected();
    compareAll();

    // Release between edges, one idle clk enables the PROM.
    rst_n  = 1'b1;
    m_ce_n = 1'b0;
    applyStimulus(1'b0);

    // Ten character periods.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1);
    checkOutput("col_after_10", 16'(char_addr[5:0]), 16'd10);

    // ch_en low: everything holds.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0);

    // One full frame from here, with row statistics taken from the DUT.
    fs_count = 0; l20 = 0; l21 = 0;
    prev_a = int'(prom_a);
    for (int i = 0; i < 19968; i++) begin
      applyStimulus(1'b1);
      if (frame_start) fs_count++;
      if (char_addr[5:0] == 6'd0) begin
        if (prom_a == 5'd20) l20++;
        if (prom_a == 5'd21) l21++;
      end
      if (int'(prom_a) != prev_a) begin
        seq.push_back(int'(prom_a));
        prev_a = int'(prom_a);
      end
    end
    checkOutput("frame_start_count", 16'(fs_count), 16'd1);
    checkOutput("row20_lines", 16'(l20), 16'd14);
    checkOutput("row21_lines", 16'(l21), 16'd18);
    checkOutput("row_visits", 16'(seq.size()), 16'd22);
    for (int i = 0; i < seq.size() && i < 22; i++)
      checkOutput("row_order", 16'(seq[i]), 16'((i + 1) % 22));

    // Move to row 7, scan 5, col 30 and reset asynchronously.
    for (int i = 0; i < 6612; i++) applyStimulus(1'b1);
    checkOutput("pre_reset_row", 16'(prom_a), 16'd7);
    checkOutput("pre_reset_scan", 16'(scan), 16'd5);
    checkOutput("pre_reset_col", 16'(char_addr[5:0]), 16'd30);
    rst_n = 1'b0;
    #2;
    modelReset();
    pushExpected();
    compareAll();
    ch_en = 1'b1;
    @(posedge clk);
    #1;
    pushExpected();
    compareAll();

    // Restart counting from col 0, across the first line wrap.
    rst_n  = 1'b1;
    m_ce_n = 1'b0;
    applyStimulus(1'b0);
    for (int i = 0; i < 70; i++) applyStimulus(1'b1);
    checkOutput("restart_col", 16'(char_addr[5:0]), 16'd6);
    checkOutput("restart_scan", 16'(scan), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
